// File: rtl/idli_mem_arb_m.sv
// idli_mem_arb_m: slice-serial shared-memory arbiter between fetch and LSU, phases aligned to i_ma_ctr 0..3.
// Define IDLI_MEM_ARB_RR_EN for round-robin resolution of simultaneous requests (default: LSU priority).
module idli_mem_arb_m (
  input  logic       i_ma_gck,
  input  logic       i_ma_rst_n,
  input  logic [1:0] i_ma_ctr,
  input  logic       i_ma_redirect,
  input  logic       i_ma_if_req,
  input  logic       i_ma_ls_req,
  input  logic       i_ma_ls_wr,
  input  logic [3:0] i_ma_if_addr,
  input  logic [3:0] i_ma_ls_addr,
  input  logic [3:0] i_ma_ls_wdata,
  output logic       o_ma_if_gnt,
  output logic       o_ma_ls_gnt,
  output logic [3:0] o_ma_rdata,
  output logic       o_ma_if_vld,
  output logic       o_ma_ls_vld,
  output logic       o_ma_mem_cs_n,
  output logic       o_ma_mem_we,
  output logic [3:0] o_ma_mem_sio,
  output logic       o_ma_mem_oe,
  input  logic [3:0] i_ma_mem_sio
);
  typedef enum logic [1:0] {IDLE, ADDR, RD, WR} state_t;
  state_t state, state_nxt;
  logic own_ls, own_ls_nxt, wr, wr_nxt, pend, pend_nxt;
  logic ctr_end, any_req, ls_win, kill, keep, busy;
  assign ctr_end = i_ma_ctr == 2'd3;
  assign any_req = i_ma_if_req | i_ma_ls_req;
  assign busy = state != IDLE;
  assign kill = pend | i_ma_redirect;
  assign keep = own_ls ? i_ma_ls_req : (i_ma_if_req & ~i_ma_ls_req & ~kill);
`ifdef IDLI_MEM_ARB_RR_EN
  logic last_if;
  assign ls_win = i_ma_ls_req & (~i_ma_if_req | last_if);
  always_ff @(posedge i_ma_gck or negedge i_ma_rst_n)
    if (!i_ma_rst_n) last_if <= 1'b1;
    else if (state == IDLE && ctr_end && any_req) last_if <= ~ls_win;
`else
  assign ls_win = i_ma_ls_req;
`endif
  always_comb begin
    state_nxt = state;
    own_ls_nxt = own_ls;
    wr_nxt = wr;
    if (ctr_end)
      case (state)
        IDLE: if (any_req) begin
          state_nxt = ADDR;
          own_ls_nxt = ls_win;
          wr_nxt = ls_win & i_ma_ls_wr;
        end
        ADDR: state_nxt = (~own_ls & kill) ? IDLE : wr ? WR : RD;
        default: state_nxt = keep ? state : IDLE;
      endcase
    pend_nxt = (state_nxt == IDLE) ? 1'b0 : pend | (busy & ~own_ls & i_ma_redirect);
  end
  always_ff @(posedge i_ma_gck or negedge i_ma_rst_n)
    if (!i_ma_rst_n) begin
      state <= IDLE;
      own_ls <= 1'b0;
      wr <= 1'b0;
      pend <= 1'b0;
    end else begin
      state <= state_nxt;
      own_ls <= own_ls_nxt;
      wr <= wr_nxt;
      pend <= pend_nxt;
    end
  // all outputs decode from registered state so reset clears them without waiting for a clock
  assign o_ma_if_gnt = busy & ~own_ls;
  assign o_ma_ls_gnt = busy & own_ls;
  assign o_ma_mem_cs_n = ~busy;
  assign o_ma_mem_we = state == WR;
  assign o_ma_mem_oe = state == ADDR || state == WR;
  assign o_ma_mem_sio = state == ADDR ? (own_ls ? i_ma_ls_addr : i_ma_if_addr) :
                        state == WR ? i_ma_ls_wdata : 4'd0;
  assign o_ma_if_vld = state == RD && !own_ls && !pend;
  assign o_ma_ls_vld = state == RD && own_ls;
  assign o_ma_rdata = (o_ma_if_vld | o_ma_ls_vld) ? i_ma_mem_sio : 4'd0;
endmodule

// File: tb/tb_idli_mem_arb_m.sv
// tb_idli_mem_arb_m: random stimulus, transaction-level reference model feeding a scoreboard queue.
module tb_idli_mem_arb_m;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] ctr = 2'd0;
  logic redirect = 1'b0, if_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0;
  logic [3:0] if_addr = 4'd0, ls_addr = 4'd0, wdata = 4'd0, mem_in = 4'd0;
  logic if_gnt, ls_gnt, if_vld, ls_vld, cs_n, we, oe;
  logic [3:0] rdata, sio;
  logic [13:0] dut_vec;
  logic [13:0] q[$];
  int total = 0, bad = 0;
  int owner = 0;
  logic addr_ph = 1'b0, wr = 1'b0, kill = 1'b0, last_ls = 1'b0;
  logic in_rst = 1'b1, done_rst = 1'b0;

  always #5 clk = ~clk;

  idli_mem_arb_m dut (
    .i_ma_gck(clk), .i_ma_rst_n(rst_n), .i_ma_ctr(ctr), .i_ma_redirect(redirect),
    .i_ma_if_req(if_req), .i_ma_ls_req(ls_req), .i_ma_ls_wr(ls_wr),
    .i_ma_if_addr(if_addr), .i_ma_ls_addr(ls_addr), .i_ma_ls_wdata(wdata),
    .o_ma_if_gnt(if_gnt), .o_ma_ls_gnt(ls_gnt), .o_ma_rdata(rdata),
    .o_ma_if_vld(if_vld), .o_ma_ls_vld(ls_vld), .o_ma_mem_cs_n(cs_n),
    .o_ma_mem_we(we), .o_ma_mem_sio(sio), .o_ma_mem_oe(oe), .i_ma_mem_sio(mem_in)
  );

  assign dut_vec = {if_gnt, ls_gnt, we, oe, sio, if_vld, ls_vld, rdata};

  task automatic check(string name, logic [13:0] act, logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // owner: 0 = no transaction, 1 = fetch, 2 = LSU; one 4-cycle phase per word boundary
  task automatic model_step();
    logic f, l, d, pick;
    logic [13:0] e;
    if (owner != 0) begin
      f = owner == 1;
      l = owner == 2;
      d = !addr_ph;
      e = {f, l, d & wr, addr_ph | wr,
           addr_ph ? (l ? ls_addr : if_addr) : (wr ? wdata : 4'h0),
           d & !wr & f & !kill, d & !wr & l,
           (d & !wr & ((f & !kill) | l)) ? mem_in : 4'h0};
      q.push_back(e);
    end
    if (owner == 1 && redirect) kill = 1'b1;
    if (ctr == 2'd3) begin
      if (owner == 0) begin
        if (ls_req || if_req) begin
`ifdef IDLI_MEM_ARB_RR_EN
          pick = ls_req && (!if_req || !last_ls);
`else
          pick = ls_req;
`endif
          owner = pick ? 2 : 1;
          addr_ph = 1'b1;
          wr = pick & ls_wr;
          last_ls = pick;
        end
      end else if (addr_ph) begin
        if (owner == 1 && kill) owner = 0;
        else addr_ph = 1'b0;
      end else if (!(owner == 2 ? ls_req : (if_req && !ls_req && !kill))) owner = 0;
      if (owner == 0) kill = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!cs_n) begin
      if (q.size() == 0) check("unexpected_activity", dut_vec, 14'h0);
      else check("bus_cycle", dut_vec, q.pop_front());
    end else begin
      check("idle_outputs", dut_vec, 14'h0);
      if (q.size() != 0) begin
        check("missing_activity", {13'h0, cs_n}, 14'h0);
        q.delete();
      end
    end
  end

  initial begin
    int rst_hold = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      ctr = ctr + 2'd1;
      if ($urandom_range(0, 5) == 0) if_req = ~if_req;
      if ($urandom_range(0, 9) == 0) ls_req = ~ls_req;
      redirect = $urandom_range(0, 11) == 0;
      ls_wr = $urandom_range(0, 1);
      if_addr = $urandom_range(0, 15);
      ls_addr = $urandom_range(0, 15);
      wdata = $urandom_range(0, 15);
      mem_in = $urandom_range(0, 15);
      if (in_rst) begin
        rst_hold++;
        if (rst_hold > 3) begin
          rst_n = 1'b1;
          in_rst = 1'b0;
          owner = 0;
          addr_ph = 1'b0;
          wr = 1'b0;
          kill = 1'b0;
          last_ls = 1'b0;
        end
      end
      if (!in_rst) model_step();
      if (!in_rst && !done_rst && c > 1500 && owner == 2 && wr && !addr_ph && ctr == 2'd2) begin
        rst_n = 1'b0;
        #1;
        check("reset_mid_wr", {~cs_n, dut_vec}, 15'h0);
        q.delete();
        done_rst = 1'b1;
        in_rst = 1'b1;
        rst_hold = 0;
      end
    end
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 14'h0);
    check("reset_inject_reached", {13'h0, done_rst}, 14'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idli_mem_arb_m.md
IDLI_MEM_ARB_M -- requirements
Module: idli_mem_arb_m

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named per the codebase as i_ma_gck and i_ma_rst_n.
REQ-002 i_ma_gck  in  1  core clock; all state updates on its rising edge.
REQ-003 i_ma_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_ma_ctr  in  2  global slice counter (ctr_t), 0..3; 3 marks the last slice of a 16b word.
REQ-005 i_ma_redirect  in  1  pipeline redirect; kills the in-flight fetch stream.
REQ-006 i_ma_if_req / i_ma_ls_req  in  1 each  fetch / load-store request for the shared memory.
REQ-007 i_ma_ls_wr  in  1  LSU request is a store (1) or load (0); sampled with the grant.
REQ-008 i_ma_if_addr / i_ma_ls_addr  in  4 each  address slice from each requester, LSB slice first.
REQ-009 i_ma_ls_wdata  in  4  store data slice.
REQ-010 o_ma_if_gnt / o_ma_ls_gnt  out  1 each  one-hot grant, held for the whole transaction.
REQ-011 o_ma_rdata  out  4  read data slice from memory.
REQ-012 o_ma_if_vld / o_ma_ls_vld  out  1 each  o_ma_rdata valid for fetch (drives decode enc_vld) / LSU.
REQ-013 o_ma_mem_cs_n  out  1  memory chip select, active low.
REQ-014 o_ma_mem_we  out  1  memory write enable, valid while cs_n low.
REQ-015 o_ma_mem_sio / o_ma_mem_oe  out  4 / 1  memory data out and its output enable.
REQ-016 i_ma_mem_sio  in  4  memory data in.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, RD, WR; every state change SHALL occur only on a cycle where i_ma_ctr==3, so every phase is exactly 4 cycles, aligned to ctr 0..3.
REQ-018 In IDLE at ctr==3: ls_req only, or both requests -> grant LSU; if_req only -> grant fetch; none -> stay IDLE.
REQ-019 The grant SHALL assert the cycle after arbitration (ctr==0) and remain asserted through the last data cycle.
REQ-020 ADDR: cs_n=0, oe=1, o_ma_mem_sio = granted requester's address slice (combinational pass-through), 4 cycles; then RD (fetch, or LSU with ls_wr=0) or WR (LSU with ls_wr=1).
REQ-021 RD: cs_n=0, oe=0, o_ma_rdata=i_ma_mem_sio, granted requester's vld=1 each cycle; zero-cycle memory latency.
REQ-022 WR: cs_n=0, oe=1, we=1, o_ma_mem_sio=i_ma_ls_wdata.
REQ-023 Burst: at ctr==3 in RD/WR, if the granted req is still high, and (for fetch) ls_req is low and no redirect is pending, the FSM SHALL stay in RD/WR for another word with incrementing address owned by memory; otherwise -> IDLE.
REQ-024 LSU SHALL preempt a fetch burst only at a word boundary (ctr==3), never mid-word.
REQ-025 Redirect during a fetch ADDR/RD phase SHALL latch a pending flag, force o_ma_if_vld=0 from the next cycle, and end the transaction at the next ctr==3 (-> IDLE); pending flag clears on entering IDLE.
REQ-026 Redirect during LSU transaction or IDLE SHALL have no effect.
REQ-027 From IDLE, cs_n SHALL stay high at least 4 cycles between transactions.
REQ-028 o_ma_rdata SHALL be 0 whenever both vld outputs are 0; o_ma_mem_sio SHALL be 0 when oe=0.
REQ-029 Dropping a req mid-word SHALL NOT shorten the word; the transaction ends at the next ctr==3.

Reset
REQ-030 Reset SHALL asynchronously force IDLE, cs_n=1, we=0, oe=0, grants=0, vld=0, rdata=0, sio=0, redirect-pending=0, even mid-transaction.
REQ-031 After reset release, first arbitration SHALL be at the first ctr==3.

Configuration
REQ-032 Macro IDLI_MEM_ARB_RR_EN: defined -> simultaneous requests in IDLE are resolved round-robin (the requester not granted last wins; reset favours LSU); undefined -> fixed LSU priority per REQ-018.

Verification
REQ-033 if_req=1 at ctr==3, addr slices 4,3,2,1 -> sio=4,3,2,1 with oe=1, then 4 cycles if_vld=1, rdata=mem data.
REQ-034 Both req at ctr==3 -> ls_gnt=1, if_gnt=0; with IDLI_MEM_ARB_RR_EN, second simultaneous arbitration -> if_gnt=1.
REQ-035 Fetch burst, ls_req raised at ctr==1 -> fetch word completes, IDLE 4 cycles, then LSU ADDR.
REQ-036 Redirect at ctr==1 of RD -> if_vld=0 at ctr 2..3, cs_n=1 from next ctr==0.
REQ-037 Store wdata 0xA,0xB,0xC,0xD -> we=1, oe=1, sio=A,B,C,D during WR.
REQ-038 Reset asserted at ctr==2 of WR -> cs_n=1, we=0, all grants/vld=0 immediately.
